// File: rtl/raifes_uart_pkg.sv
// raifes_uart_pkg
// Shared definitions for the raifes UART transmitter:
//   - uart_state_e : 3-bit frame FSM state encoding
//   - PARITY_*     : encodings of the PARITY parameter
//   - frame_cycles : clock cycles taken by one complete frame
package raifes_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Total frame duration in clock cycles. Any parity code other than odd or
  // even (including the illegal value 3) adds no parity bit.
  function automatic int frame_cycles(input int clk_div, input int data_bits,
                                      input int parity, input int stop_bits);
    int par_bits;
    par_bits = (parity == PARITY_ODD || parity == PARITY_EVEN) ? 1 : 0;
    return (1 + data_bits + par_bits + stop_bits) * clk_div;
  endfunction

endpackage

// File: rtl/raifes_sync_fifo.sv
// raifes_sync_fifo
// Single-clock FIFO with registered occupancy flags.
// Ports:
//   clk, reset : clock, synchronous active-high reset (pointers and flags)
//   push, din  : write strobe and data; a push while full is dropped
//   pop, dout  : read strobe; dout always shows the entry at the read pointer
//   full, empty: registered status flags
//   count      : registered number of occupied entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module raifes_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    // A simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/raifes_uart_tx.sv
// raifes_uart_tx
// Buffered UART transmitter with a configurable frame format.
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset; aborts any frame, flushes FIFO
//   wdata      : byte to send, bits above DATA_BITS are ignored
//   wvalid     : write request, accepted on an edge where wvalid && wready
//   wready     : FIFO not full
//   UART_TX    : registered serial output, idles high
//   busy       : frame in progress or bytes still queued
//   fifo_count : number of queued bytes
// Frame: start(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS
// stop bits (1), each bit lasting CLK_DIV cycles. Queued bytes follow each
// other with no idle gap.
module raifes_uart_tx
  import raifes_uart_pkg::*;
#(
  parameter int CLK_DIV    = 217,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    wdata,
  input  logic                          wvalid,
  output logic                          wready,
  output logic                          UART_TX,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLK_DIV - 1);
  localparam logic [2:0]    LAST_DATA    = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP    = 3'(STOP_BITS - 1);
  localparam logic [7:0]    DATA_MASK    = 8'((1 << DATA_BITS) - 1);
  // The illegal code 3 falls through to "no parity".
  localparam bit PAR_EN  = (PARITY == PARITY_ODD) || (PARITY == PARITY_EVEN);
  localparam bit PAR_ODD = (PARITY == PARITY_ODD);

  uart_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;      // data bit index in DATA, stop bit index in STOP
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          tick;
  logic          pop_req;

  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;

  // Parity bit that makes the frame's count of ones odd or even, taken over
  // the transmitted data bits only.
  function automatic logic parity_bit(input logic [7:0] data);
    logic ones;
    ones = ^(data & DATA_MASK);
    return PAR_ODD ? ~ones : ones;
  endfunction

  raifes_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wvalid),
    .pop   (pop_req),
    .din   (wdata),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign wready = !fifo_full;
  assign busy   = (state_q != ST_IDLE) || !fifo_empty;
  assign tick   = (timer_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= TIMER_RELOAD;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Byte being shifted out and its parity; only meaningful once loaded.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    pop_req = 1'b0;

    // Outside IDLE the timer free-runs; expiry marks the end of a bit.
    if (state_q != ST_IDLE) begin
      timer_d = tick ? TIMER_RELOAD : timer_q - 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_req = 1'b1;
          shreg_d = fifo_dout;
          par_d   = parity_bit(fifo_dout);
          timer_d = TIMER_RELOAD;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            bit_d = '0;
            // Chain straight into the next start bit when more data waits.
            if (!fifo_empty) begin
              pop_req = 1'b1;
              shreg_d = fifo_dout;
              par_d   = parity_bit(fifo_dout);
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: the line level for the current state, registered into tx_q
  // so the pin follows the FSM by one cycle and never glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_q[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
  end

  assign UART_TX = tx_q;

endmodule

// File: tb/tb_raifes_uart_tx.sv
// Testbench for raifes_uart_tx: several parameterisations instantiated side
// by side, exercised one at a time against a frame-level reference model.
module tb_raifes_uart_tx;
  import raifes_uart_pkg::*;

  localparam int NC   = 6;
  localparam int CD [NC] = '{4, 4, 4, 4, 2, 3};
  localparam int DB [NC] = '{8, 8, 8, 5, 7, 6};
  localparam int PA [NC] = '{0, 2, 1, 1, 2, 3};
  localparam int SB [NC] = '{1, 1, 1, 2, 2, 1};
  localparam int DP [NC] = '{16, 16, 16, 16, 4, 8};
  localparam int LOGN = 32768;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [NC-1:0]        wvalid, wready, tx, busy;
  logic [NC-1:0][7:0]   wdata;
  logic [NC-1:0][4:0]   cnt;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    logic [$clog2(DP[g]):0] cnt_l;
    raifes_uart_tx #(
      .CLK_DIV    (CD[g]),
      .DATA_BITS  (DB[g]),
      .PARITY     (PA[g]),
      .STOP_BITS  (SB[g]),
      .FIFO_DEPTH (DP[g])
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .wdata      (wdata[g]),
      .wvalid     (wvalid[g]),
      .wready     (wready[g]),
      .UART_TX    (tx[g]),
      .busy       (busy[g]),
      .fifo_count (cnt_l)
    );
    assign cnt[g] = 5'(cnt_l);
  end

  int cur, cyc, checks, errors, prev_end;
  int fE[$];            // edge at which each byte was accepted
  int fS[$];            // first sample cycle its start bit is on the line
  logic [15:0] fB[$];   // frame bits in time order
  logic txlog [LOGN];
  logic busylog [LOGN];

  function automatic int nbits();
    return 1 + DB[cur] + ((PA[cur] == PARITY_ODD || PA[cur] == PARITY_EVEN) ? 1 : 0) + SB[cur];
  endfunction

  function automatic logic [15:0] build_frame(input logic [7:0] d);
    logic [15:0] f;
    int ones, n;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DB[cur]; i++) begin
      f[1 + i] = d[i];
      if (d[i]) ones++;
    end
    n = 1 + DB[cur];
    if (PA[cur] == PARITY_ODD)       f[n] = ((ones % 2) == 0);
    else if (PA[cur] == PARITY_EVEN) f[n] = ((ones % 2) == 1);
    return f;
  endfunction

  function automatic logic exp_tx(input int c);
    logic [15:0] f;
    int len;
    len = nbits() * CD[cur];
    for (int k = 0; k < fS.size(); k++) begin
      if (c >= fS[k] && c < fS[k] + len) begin
        f = fB[k];
        return f[(c - fS[k]) / CD[cur]];
      end
    end
    return 1'b1;
  endfunction

  // Busy from the accepting edge until the FSM returns to idle, which is one
  // cycle before the line finishes the last stop bit.
  function automatic logic exp_busy(input int c);
    int len;
    len = nbits() * CD[cur];
    for (int k = 0; k < fS.size(); k++)
      if (c >= fE[k] && c < fS[k] - 1 + len) return 1'b1;
    return 1'b0;
  endfunction

  // A byte occupies the FIFO until the edge before its start bit appears.
  function automatic int exp_cnt(input int c);
    int n;
    n = 0;
    for (int k = 0; k < fS.size(); k++)
      if (c >= fE[k] && c < fS[k] - 1) n++;
    return n;
  endfunction

  task automatic model_clear();
    fE.delete();
    fS.delete();
    fB.delete();
    prev_end = 0;
  endtask

  task automatic add_frame(input logic [7:0] d);
    int s;
    s = (cyc + 2 > prev_end) ? cyc + 2 : prev_end;
    fE.push_back(cyc);
    fS.push_back(s);
    fB.push_back(build_frame(d));
    prev_end = s + nbits() * CD[cur];
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs();
    logic e_tx, e_busy, e_rdy;
    int   e_cnt;
    e_tx   = exp_tx(cyc);
    e_busy = exp_busy(cyc);
    e_cnt  = exp_cnt(cyc);
    e_rdy  = (e_cnt < DP[cur]);
    if (cyc < LOGN) begin
      txlog[cyc]   = tx[cur];
      busylog[cyc] = busy[cur];
    end
    checks++;
    assert (tx[cur] === e_tx) else begin
      errors++;
      $error("FAIL tx cfg=%0d cyc=%0d observed=%b expected=%b", cur, cyc, tx[cur], e_tx);
    end
    checks++;
    assert (busy[cur] === e_busy) else begin
      errors++;
      $error("FAIL busy cfg=%0d cyc=%0d observed=%b expected=%b", cur, cyc, busy[cur], e_busy);
    end
    checks++;
    assert (int'(cnt[cur]) === e_cnt) else begin
      errors++;
      $error("FAIL fifo_count cfg=%0d cyc=%0d observed=%0d expected=%0d", cur, cyc, cnt[cur], e_cnt);
    end
    checks++;
    assert (wready[cur] === e_rdy) else begin
      errors++;
      $error("FAIL wready cfg=%0d cyc=%0d observed=%b expected=%b", cur, cyc, wready[cur], e_rdy);
    end
  endtask

  // One clock: check outputs at the falling edge, drive, advance.
  task automatic step(input logic v, input logic [7:0] d, output logic acc);
    check_outputs();
    wvalid       = '0;
    wvalid[cur]  = v;
    wdata[cur]   = d;
    acc = v && (exp_cnt(cyc) < DP[cur]);
    @(posedge clk);
    cyc++;
    if (acc) add_frame(d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, a);
  endtask

  task automatic drain();
    logic a;
    while (cyc < prev_end + 3) step(1'b0, 8'h00, a);
  endtask

  task automatic select_cfg(input int k);
    wvalid = '0;
    cur = k;
    model_clear();
  endtask

  task automatic busy_fall(input string tag, input int e0, input int exp_v);
    int c;
    c = e0;
    while (c < e0 + 400 && c < LOGN - 1 && busylog[c] !== 1'b0) c++;
    chk(tag, c, exp_v);
  endtask

  initial begin
    logic        a;
    int          e0, c0, nacc, gap;
    logic [9:0]  pat;
    checks = 0; errors = 0; cyc = 0; cur = 0;
    reset = 1'b1; wvalid = '0; wdata = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", int'(tx[0]), 1);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_count", int'(cnt[0]), 0);
    chk("reset_wready", int'(wready[0]), 1);
    reset = 1'b0;

    // 8N1, 0xA5
    select_cfg(0);
    idle(3);
    step(1'b1, 8'hA5, a);
    e0 = cyc;
    drain();
    pat = 10'b1101001010;
    chk("t1_before_start", int'(txlog[e0 + 1]), 1);
    for (int b = 0; b < 10; b++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("t1_bit%0d_c%0d", b, j), int'(txlog[e0 + 2 + b * 4 + j]), int'(pat[b]));
    busy_fall("t1_busy_fall", e0, e0 + 1 + frame_cycles(4, 8, 0, 1));

    // 8E1 and 8O1 with 0x03
    select_cfg(1);
    step(1'b1, 8'h03, a);
    e0 = cyc;
    drain();
    chk("t2_even_parity", int'(txlog[e0 + 2 + 9 * 4 + 1]), 0);
    busy_fall("t2_even_busy_fall", e0, e0 + 1 + 44);
    select_cfg(2);
    step(1'b1, 8'h03, a);
    e0 = cyc;
    drain();
    chk("t2_odd_parity", int'(txlog[e0 + 2 + 9 * 4 + 1]), 1);
    busy_fall("t2_odd_busy_fall", e0, e0 + 1 + 44);

    // 5O2 with 0xFF: five ones, parity 0, two stop bits
    select_cfg(3);
    step(1'b1, 8'hFF, a);
    e0 = cyc;
    drain();
    for (int b = 1; b <= 5; b++) chk($sformatf("t3_data%0d", b), int'(txlog[e0 + 2 + b * 4]), 1);
    chk("t3_parity", int'(txlog[e0 + 2 + 6 * 4 + 2]), 0);
    for (int j = 0; j < 8; j++) chk($sformatf("t3_stop%0d", j), int'(txlog[e0 + 2 + 28 + j]), 1);
    busy_fall("t3_busy_fall", e0, e0 + 1 + 36);

    // back-to-back frames
    select_cfg(0);
    step(1'b1, 8'h55, a);
    e0 = cyc;
    step(1'b1, 8'hAA, a);
    drain();
    chk("t4_last_stop", int'(txlog[e0 + 41]), 1);
    chk("t4_second_start", int'(txlog[e0 + 42]), 0);
    busy_fall("t4_busy_fall", e0, e0 + 1 + 80);

    // fill the FIFO
    nacc = 0;
    c0 = cyc;
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 8'($urandom()), a);
      if (a) nacc++;
    end
    chk("t5_accepted", nacc, 17);
    chk("t5_count_full", int'(cnt[0]), 16);
    chk("t5_wready_full", int'(wready[0]), 0);
    e0 = c0 + 1;
    while (cyc < e0 + 40) step(1'b0, 8'h00, a);
    chk("t5_wready_before_pop", int'(wready[0]), 0);
    step(1'b0, 8'h00, a);
    chk("t5_wready_after_pop", int'(wready[0]), 1);
    drain();

    // reset during data bit 3 with three bytes queued
    step(1'b1, 8'h11, a);
    e0 = cyc;
    step(1'b1, 8'h22, a);
    step(1'b1, 8'h33, a);
    step(1'b1, 8'h44, a);
    while (cyc < e0 + 2 + 17) step(1'b0, 8'h00, a);
    check_outputs();
    reset = 1'b1;
    wvalid = '0;
    @(posedge clk);
    cyc++;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    chk("t6_tx", int'(tx[0]), 1);
    chk("t6_count", int'(cnt[0]), 0);
    chk("t6_busy", int'(busy[0]), 0);
    chk("t6_wready", int'(wready[0]), 1);
    step(1'b1, 8'h0F, a);
    e0 = cyc;
    drain();
    pat = 10'b1000011110;
    for (int b = 0; b < 10; b++)
      chk($sformatf("t6_bit%0d", b), int'(txlog[e0 + 2 + b * 4 + 2]), int'(pat[b]));

    // randomized traffic on every configuration
    for (int k = 0; k < NC; k++) begin
      select_cfg(k);
      for (int n = 0; n < 25; n++) begin
        step(1'b1, 8'($urandom()), a);
        gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 3 * nbits() * CD[k]);
        idle(gap);
      end
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
